mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_pkg.sv | 22 ++
 rtl/iter_cnt.sv | 32 +++
 rtl/mul_ctrl.sv | 121 ++++++++++++
 tb/tb_mul_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-free add/decrement multiplier:
// controller state encoding, default widths and counter sizing helper.
package mul_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int MAX_ITER_DEF = 65535;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } mul_state_e;

    // Bits needed to hold every count from 0 up to and including max_iter.
    function automatic int cnt_width(input int max_iter);
        return (max_iter < 2) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/iter_cnt.sv
// Iteration counter for the CALC loop: synchronous clear, count enable,
// terminal-count flag when the count reaches MAX_ITER.
module iter_cnt
    import mul_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(MAX_ITER);

    logic [W-1:0] cnt;

    // clear wins so a fresh CALC entry always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(MAX_ITER));

endmodule

// File: rtl/mul_ctrl.sv
// Controller for a repeated-addition multiplier: loads A and B from a shared
// operand bus, adds A into P while decrementing B until B == 0 or a limit.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       data_valid,
    input  logic       eqz,
    output logic       ldA,
    output logic       ldB,
    output logic       clrP,
    output logic       ldP,
    output logic       decB,
    output logic       busy,
    output logic       done,
    output logic       err,
    output mul_state_e dbg_state
);

    // Handshake: start is a level held by the requester until done or err is
    // seen; dropping it early aborts. data_valid qualifies the operand bus for
    // exactly the cycle it is high, and a load strobe consumes it that cycle.

    if (DATA_W < 1 || MAX_ITER < 1) begin : g_bad_param
        $error("mul_ctrl: DATA_W and MAX_ITER must be at least 1");
    end

    mul_state_e state_q;
    mul_state_e state_d;
    logic       cnt_clr;
    logic       at_limit;

    iter_cnt #(
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (decB),
        .tc    (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are gated by start so an abort issues no further datapath work.
    always_comb begin
        state_d = state_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        clrP    = 1'b0;
        ldP     = 1'b0;
        decB    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                busy = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end else if (data_valid) begin
                    ldA     = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                busy = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end else if (data_valid) begin
                    ldB     = 1'b1;
                    clrP    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end else if (eqz) begin
                    state_d = DONE;
                end else if (at_limit) begin
                    state_d = ERR;
                end else begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            ERR: begin
                err = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural A/B/P datapath and a
// product scoreboard popped whenever the controller reports done.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int DW     = 16;
  localparam int MAX_IT = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            data_valid = 1'b0;
  logic            eqz;
  logic            lda, ldb, clrp, ldp, decb, busy, done, err;
  mul_state_e      dbg_state;

  logic [DW-1:0]   bus = '0;
  logic [DW-1:0]   a_reg = '0;
  logic [DW-1:0]   b_reg = '0;
  logic [2*DW-1:0] p_reg = '0;
  logic            force_nz = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_lda = 0, n_ldb = 0, n_clrp = 0, n_ldp = 0, n_decb = 0, n_done = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] exp_p;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mul_ctrl #(
    .DATA_W   (DW),
    .MAX_ITER (MAX_IT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_valid (data_valid),
    .eqz        (eqz),
    .ldA        (lda),
    .ldB        (ldb),
    .clrP       (clrp),
    .ldP        (ldp),
    .decB       (decb),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // behavioural datapath
  assign eqz = force_nz ? 1'b0 : (b_reg == '0);

  always @(posedge clk) begin
    if (lda) a_reg <= bus;
    if (ldb) b_reg <= bus;
    else if (decb) b_reg <= b_reg - 1'b1;
    if (clrp) p_reg <= '0;
    else if (ldp) p_reg <= p_reg + {{DW{1'b0}}, a_reg};
  end

  // strobe monitor
  always @(negedge clk) begin
    if (lda)  n_lda++;
    if (ldb)  n_ldb++;
    if (clrp) n_clrp++;
    if (ldp)  n_ldp++;
    if (decb) n_decb++;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_lda = 0; n_ldb = 0; n_clrp = 0; n_ldp = 0; n_decb = 0; n_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // driver: raise start, present A then B with optional bus stalls;
  // returns one time unit after the edge that enters CALC
  task automatic load_ops(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int sa, input int sb);
    clear_counts();
    cyc = 0;
    start = 1'b1;
    data_valid = 1'b0;
    tick();
    repeat (sa) tick();
    bus = a;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (sb) tick();
    bus = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    while (!(done || err) && cyc < budget) tick();
  endtask

  task automatic run_mul(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int sa, input int sb);
    exp_q.push_back({{DW{1'b0}}, a} * {{DW{1'b0}}, b});
    load_ops(a, b, sa, sb);
    wait_end(400);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, cyc, b + 4 + sa + sb);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_lda_pulses"}, n_lda, 1);
    check({tag, "_ldb_pulses"}, n_ldb, 1);
    check({tag, "_clrp_pulses"}, n_clrp, 1);
    check({tag, "_ldp_pulses"}, n_ldp, b);
    check({tag, "_decb_pulses"}, n_decb, b);
    if (done) begin
      exp_p = exp_q.pop_front();
      check({tag, "_product"}, p_reg, exp_p);
    end
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_idle_after"}, dbg_state, IDLE);
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_err_low"}, err, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    int rsa, rsb;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_outputs", {lda, ldb, clrp, ldp, decb, busy, done, err}, 8'h00);
    start = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_idle", dbg_state, IDLE);
    start = 1'b0;
    data_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", dbg_state, IDLE);

    // nominal 7 x 3, then hold start in DONE for 4 cycles
    run_mul("nominal", 16'd7, 16'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_done", done, 1'b1);
      check("hold_busy", busy, 1'b0);
    end
    check("hold_no_reload", n_lda, 1);
    release_start("nominal");

    // zero operand
    run_mul("zero", 16'd9, 16'd0, 0, 0);
    release_start("zero");

    // stalled operand bus
    run_mul("stall", 16'd7, 16'd3, 5, 3);
    release_start("stall");

    // iteration limit fault
    force_nz = 1'b1;
    load_ops(16'd5, 16'd2, 0, 0);
    wait_end(400);
    check("fault_err", err, 1'b1);
    check("fault_busy", busy, 1'b0);
    check("fault_done", done, 1'b0);
    check("fault_latency", cyc, MAX_IT + 4);
    check("fault_decb_pulses", n_decb, MAX_IT);
    check("fault_ldp_pulses", n_ldp, MAX_IT);
    tick();
    check("fault_err_hold", err, 1'b1);
    release_start("fault");
    force_nz = 1'b0;

    // abort in the second CALC cycle
    load_ops(16'd4, 16'd5, 0, 0);
    check("abort_first_calc_ldp", ldp, 1'b1);
    tick();
    start = 1'b0;
    #1;
    check("abort_ldp_gated", ldp, 1'b0);
    check("abort_decb_gated", decb, 1'b0);
    tick();
    check("abort_idle", dbg_state, IDLE);
    check("abort_busy", busy, 1'b0);
    repeat (8) tick();
    check("abort_no_done", n_done, 0);
    check("abort_decb_pulses", n_decb, 1);

    // asynchronous reset mid-CALC
    load_ops(16'd3, 16'd6, 0, 0);
    tick();
    #2;
    check("rstcalc_ldp_before", ldp, 1'b1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("rstcalc_ldp", ldp, 1'b0);
    check("rstcalc_decb", decb, 1'b0);
    check("rstcalc_busy", busy, 1'b0);
    check("rstcalc_state", dbg_state, IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstcalc_idle_after", dbg_state, IDLE);
    start = 1'b1;
    tick();
    check("rstcalc_restart_state", dbg_state, LOAD_A);
    check("rstcalc_restart_busy", busy, 1'b1);
    start = 1'b0;
    tick();
    check("rstcalc_restart_abort", dbg_state, IDLE);

    // randomised operands through the same scoreboard
    for (int k = 0; k < 3; k++) begin
      ra  = DW'($urandom_range(1, 200));
      rb  = DW'($urandom_range(0, 7));
      rsa = $urandom_range(0, 2);
      rsb = $urandom_range(0, 2);
      run_mul("random", ra, rb, rsa, rsb);
      release_start("random");
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
